// File: rtl/wb_picorv32_master.sv
// wb_picorv32_master
// Bridges the picorv32 native memory bus onto single-beat Wishbone B4
// pipelined cycles, one transaction in flight at a time. Responder errors
// and watchdog aborts finish the CPU access with ERR_DATA and are counted.
//
// Handshakes:
//   CPU side: the core holds i_mem_valid and the request fields steady until
//   it sees o_mem_ready. o_mem_ready is a one-cycle pulse, and o_mem_rdata is
//   meaningful only in that cycle. A new request is sampled no earlier than
//   the cycle after the pulse.
//   Wishbone side: the request is accepted on an edge where o_wb_stb=1 and
//   i_wb_stall=0. Completion is the first edge with CYC=1 and i_wb_ack or
//   i_wb_err high. That edge may be the acceptance edge itself. Only while
//   stalled is ack/err ignored.
module wb_picorv32_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_err,
    output logic        o_bus_err,
    output logic [7:0]  o_err_count,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Watchdog fires on the last of TIMEOUT_CYCLES cycles with CYC high.
    localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 1;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_err_count;
    logic [31:0] r_wdog;

    logic        w_accept;
    logic        w_complete;
    logic        w_fail;
    logic        w_timeout;

    // The fetch flag carries no meaning for the bus.
    logic        w_unused_instr;
    assign w_unused_instr = i_mem_instr;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, completion classification and bus-facing outputs.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_fail      = 1'b0;
        w_timeout   = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_LAST);
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_mem_ready = 1'b0;
        o_mem_rdata = 32'h0;
        o_bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_mem_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
                    // Accepted and answered on the same edge.
                    w_complete = 1'b1;
                    w_fail     = i_wb_err;
                end else if (w_timeout) begin
                    w_complete = 1'b1;
                    w_fail     = 1'b1;
                end else if (!i_wb_stall) begin
                    w_next = S_WAIT;
                end
                if (w_complete) begin
                    w_next = S_DONE;
                end
            end
            S_WAIT: begin
                o_wb_cyc = 1'b1;
                if (i_wb_ack || i_wb_err) begin
                    w_complete = 1'b1;
                    w_fail     = i_wb_err;
                end else if (w_timeout) begin
                    w_complete = 1'b1;
                    w_fail     = 1'b1;
                end
                if (w_complete) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_mem_ready = 1'b1;
                o_mem_rdata = r_rdata;
                o_bus_err   = r_err;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, response capture, watchdog and error counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_sel       <= 4'h0;
            r_we        <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_err_count <= 8'h0;
            r_wdog      <= 32'h0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_mem_addr;
                r_wdata <= i_mem_wdata;
                r_sel   <= (i_mem_wstrb == 4'b0000) ? 4'b1111 : i_mem_wstrb;
                r_we    <= (i_mem_wstrb != 4'b0000);
            end
            if (o_wb_cyc && !w_complete) begin
                r_wdog <= r_wdog + 32'd1;
            end else begin
                r_wdog <= 32'h0;
            end
            if (w_complete) begin
                r_err <= w_fail;
                if (w_fail) begin
                    r_rdata <= ERR_DATA;
                end else if (r_we) begin
                    r_rdata <= 32'h0;
                end else begin
                    r_rdata <= i_wb_data;
                end
                if (w_fail && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign o_wb_addr   = r_addr;
    assign o_wb_data   = r_wdata;
    assign o_wb_sel    = r_sel;
    assign o_wb_we     = r_we;
    assign o_err_count = r_err_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_picorv32_master.sv
// Directed bench for wb_picorv32_master (watchdog shortened to 8 cycles).
module tb_wb_picorv32_master;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        wb_err;
    logic        bus_err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    // Responder model: either directly driven, or answering combinationally
    // to an accepted strobe.
    logic        tb_ack;
    logic        tb_err;
    logic        ack_mode;
    logic        err_mode;

    int          tests;
    int          fails;
    int          n_ok;
    logic [31:0] exp_q[$];

    assign wb_ack = tb_ack | (ack_mode & wb_stb & ~wb_stall);
    assign wb_err = tb_err | (err_mode & wb_stb & ~wb_stall);

    wb_picorv32_master #(
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_mem_valid(mem_valid),
        .i_mem_instr(mem_instr),
        .i_mem_addr (mem_addr),
        .i_mem_wdata(mem_wdata),
        .i_mem_wstrb(mem_wstrb),
        .o_mem_ready(mem_ready),
        .o_mem_rdata(mem_rdata),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_wdata),
        .o_wb_sel   (wb_sel),
        .i_wb_stall (wb_stall),
        .i_wb_ack   (wb_ack),
        .i_wb_data  (wb_rdata),
        .i_wb_err   (wb_err),
        .o_bus_err  (bus_err),
        .o_err_count(err_count),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Completion cycle: compare returned data against the scoreboard head.
    task automatic check_rdata(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, mem_rdata, e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        wb_stall  = 1'b0;
        wb_rdata  = 32'h0;
        tb_ack    = 1'b0;
        tb_err    = 1'b0;
        ack_mode  = 1'b0;
        err_mode  = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_cyc", {31'h0, wb_cyc}, 32'h0);
        check("rst_stb", {31'h0, wb_stb}, 32'h0);
        check("rst_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_addr", wb_addr, 32'h0);
        check("rst_cnt", {24'h0, err_count}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        reset = 1'b0;
        tick();

        // 1. Zero-wait write with ack following the strobe.
        ack_mode = 1'b1;
        issue(32'h8000_0000, 32'h0000_002A, 4'b1111);
        exp_q.push_back(32'h0);
        tick();
        check("t1_cyc", {31'h0, wb_cyc}, 32'h1);
        check("t1_stb", {31'h0, wb_stb}, 32'h1);
        check("t1_we", {31'h0, wb_we}, 32'h1);
        check("t1_sel", {28'h0, wb_sel}, 32'hF);
        check("t1_addr", wb_addr, 32'h8000_0000);
        check("t1_data", wb_wdata, 32'h2A);
        check("t1_ready_c1", {31'h0, mem_ready}, 32'h0);
        tick();
        check("t1_ready_c2", {31'h0, mem_ready}, 32'h1);
        check("t1_cyc_c2", {31'h0, wb_cyc}, 32'h0);
        check("t1_state_c2", {30'h0, dbg_state}, 32'h3);
        check_rdata("t1_rdata");
        tick();
        mem_valid = 1'b0;
        check("t1_ready_c3", {31'h0, mem_ready}, 32'h0);
        tick();
        check("t1_no_reissue", {31'h0, wb_cyc}, 32'h0);
        ack_mode = 1'b0;

        // 2. Read stalled for three cycles, ack two cycles after acceptance.
        wb_stall = 1'b1;
        issue(32'h0000_1000, 32'h0, 4'b0000);
        exp_q.push_back(32'h1234_5678);
        tick();
        check("t2_stb_c1", {31'h0, wb_stb}, 32'h1);
        tick();
        check("t2_stb_c2", {31'h0, wb_stb}, 32'h1);
        tick();
        check("t2_stb_c3", {31'h0, wb_stb}, 32'h1);
        tick();
        wb_stall = 1'b0;
        check("t2_stb_c4", {31'h0, wb_stb}, 32'h1);
        tick();
        check("t2_stb_c5", {31'h0, wb_stb}, 32'h0);
        check("t2_cyc_c5", {31'h0, wb_cyc}, 32'h1);
        tick();
        tb_ack   = 1'b1;
        wb_rdata = 32'h1234_5678;
        check("t2_cyc_c6", {31'h0, wb_cyc}, 32'h1);
        check("t2_ready_c6", {31'h0, mem_ready}, 32'h0);
        tick();
        tb_ack = 1'b0;
        check("t2_ready", {31'h0, mem_ready}, 32'h1);
        check("t2_buserr", {31'h0, bus_err}, 32'h0);
        check_rdata("t2_rdata");
        tick();
        mem_valid = 1'b0;

        // 3. Byte-lane write, then a full-word read.
        ack_mode = 1'b1;
        issue(32'h8000_0004, 32'hAABB_CCDD, 4'b0100);
        exp_q.push_back(32'h0);
        tick();
        check("t3_wsel", {28'h0, wb_sel}, 32'h4);
        check("t3_wwe", {31'h0, wb_we}, 32'h1);
        check("t3_wdata", wb_wdata, 32'hAABB_CCDD);
        tick();
        check_rdata("t3_wrdata");
        tick();
        mem_valid = 1'b0;
        wb_rdata  = 32'hCAFE_F00D;
        issue(32'h0000_2000, 32'h5555_5555, 4'b0000);
        exp_q.push_back(32'hCAFE_F00D);
        tick();
        check("t3_rsel", {28'h0, wb_sel}, 32'hF);
        check("t3_rwe", {31'h0, wb_we}, 32'h0);
        check("t3_raddr", wb_addr, 32'h0000_2000);
        tick();
        check("t3_rready", {31'h0, mem_ready}, 32'h1);
        check_rdata("t3_rdata");
        tick();
        mem_valid = 1'b0;
        ack_mode  = 1'b0;

        // 4. Error and ack together on the acceptance edge.
        issue(32'h0000_3000, 32'h0, 4'b0000);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        tb_ack = 1'b1;
        tb_err = 1'b1;
        check("t4_cnt_before", {24'h0, err_count}, 32'h0);
        tick();
        tb_ack = 1'b0;
        tb_err = 1'b0;
        check("t4_ready", {31'h0, mem_ready}, 32'h1);
        check("t4_buserr", {31'h0, bus_err}, 32'h1);
        check("t4_cnt", {24'h0, err_count}, 32'h1);
        check_rdata("t4_rdata");
        tick();
        mem_valid = 1'b0;
        check("t4_buserr_off", {31'h0, bus_err}, 32'h0);

        // 5. Watchdog: no response at all, abort after 8 CYC cycles.
        issue(32'h0000_4000, 32'h0, 4'b0000);
        exp_q.push_back(32'hDEAD_BEEF);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t5_cyc_c%0d", i), {31'h0, wb_cyc}, 32'h1);
        end
        tick();
        check("t5_cyc_drop", {31'h0, wb_cyc}, 32'h0);
        check("t5_ready", {31'h0, mem_ready}, 32'h1);
        check("t5_buserr", {31'h0, bus_err}, 32'h1);
        check("t5_cnt", {24'h0, err_count}, 32'h2);
        check_rdata("t5_rdata");
        tick();
        mem_valid = 1'b0;
        tb_ack    = 1'b1;
        wb_rdata  = 32'h1111_1111;
        tick();
        tb_ack = 1'b0;
        check("t5_late_ready", {31'h0, mem_ready}, 32'h0);
        check("t5_late_cnt", {24'h0, err_count}, 32'h2);
        check("t5_late_cyc", {31'h0, wb_cyc}, 32'h0);

        // 6a. Reset while waiting for a response.
        issue(32'h0000_5000, 32'h0, 4'b0000);
        tick();
        tick();
        check("t6_wait_cyc", {31'h0, wb_cyc}, 32'h1);
        check("t6_wait_stb", {31'h0, wb_stb}, 32'h0);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mem_valid = 1'b0;
        check("t6_rst_cyc", {31'h0, wb_cyc}, 32'h0);
        check("t6_rst_ready", {31'h0, mem_ready}, 32'h0);
        check("t6_rst_cnt", {24'h0, err_count}, 32'h0);
        tick();
        check("t6_rst_ready2", {31'h0, mem_ready}, 32'h0);

        // 6b. 300 error completions saturate the counter at 255.
        err_mode = 1'b1;
        n_ok     = 0;
        for (int i = 0; i < 300; i++) begin
            issue(32'h0000_6000 + 32'(i * 4), 32'h0, 4'b0000);
            tick();
            tick();
            if (mem_ready && bus_err && (mem_rdata == 32'hDEAD_BEEF)) n_ok++;
            if (i == 253) check("t6_cnt_254", {24'h0, err_count}, 32'd254);
            if (i == 254) check("t6_cnt_255", {24'h0, err_count}, 32'd255);
            mem_valid = 1'b0;
            tick();
        end
        err_mode = 1'b0;
        check("t6_err_done", n_ok, 32'd300);
        check("t6_cnt_sat", {24'h0, err_count}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
